mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter that sits on the CPU data bus beside data_memory.
//  The CPU drives MemWrite/ALUResult/WriteData; this block decodes its address window.
//  It returns read data in the same cycle, as the single-cycle core requires.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/mmio_uart_tx_if.sv | 12 +
 rtl/sync_fifo.sv | 43 ++++
 rtl/mmio_uart_tx.sv | 176 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, divider width and the serializer state encoding (UART_TX_PARITY_EN adds PARITY).
package uart_pkg;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_BAUDDIV = 2'd2;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  localparam int DIV_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-bus view of the UART window: write strobe, address and data in,
// combinational read data and window hit out.
interface mmio_uart_tx_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        hit;

  modport master (output we, a, wd, input rd, hit);
  modport slave  (input we, a, wd, output rd, hit);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; the caller only pushes when not full or when popping in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: bus decode, TX FIFO and 8N1 serializer
// (8E1 when UART_TX_PARITY_EN is defined).
module mmio_uart_tx
  import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic            clk,
    input  logic            rst,
    mmio_uart_tx_if.slave   bus,
    output logic            tx,
    output logic            irq,
    output uart_state_e     dbg_state_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    uart_state_e      state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_lat_q, div_lat_d, baud_q, baud_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_q, bit_d;
    logic             par_q, par_d, tx_q, tx_d, irq_q, irq_d, ovf_q, ovf_d;

    logic [7:0]    fifo_data;
    logic [CW-1:0] fifo_count, cnt_next;
    logic          fifo_full, fifo_empty;
    logic          wr, push, push_ok, pop, load, bit_end;
    logic [1:0]    off;
    logic [3:0]    cnt4;
    logic [31:0]   cnt32;
    logic          unused_bits;

    assign off         = bus.a[3:2];
    assign bus.hit     = (bus.a[31:4] == BASE_ADDR[31:4]);
    assign wr          = bus.we & bus.hit;
    assign push        = wr && (off == OFF_TXDATA);
    assign push_ok     = push && (!fifo_full || pop);
    assign bit_end     = (cnt_q == DIV_W'(1));
    assign unused_bits = ^{bus.a[1:0], bus.wd[31:16]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_ok),
        .data_i  (bus.wd[7:0]),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Count field saturates at 15 so deeper FIFOs still fit the 4-bit STATUS slot.
    assign cnt32 = 32'(fifo_count);
    assign cnt4  = (cnt32 > 32'd15) ? 4'hF : cnt32[3:0];

    always_comb begin
        bus.rd = '0;
        if (bus.hit) begin
            case (off)
                OFF_STATUS: begin
                    bus.rd[ST_BUSY]               = (state_q != S_IDLE);
                    bus.rd[ST_FULL]               = fifo_full;
                    bus.rd[ST_EMPTY]              = fifo_empty;
                    bus.rd[ST_OVF]                = ovf_q;
                    bus.rd[ST_CNT_LSB+3:ST_CNT_LSB] = cnt4;
                end
                OFF_BAUDDIV: bus.rd[DIV_W-1:0] = baud_q;
                default:     bus.rd = '0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_lat_d = div_lat_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        par_d     = par_q;
        tx_d      = tx_q;
        load      = 1'b0;
        if (state_q != S_IDLE) cnt_d = bit_end ? div_lat_q : cnt_q - DIV_W'(1);
        case (state_q)
            S_IDLE:  load = !fifo_empty;
            S_START: if (bit_end) begin
                state_d = S_DATA;
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
                bit_d   = 3'd0;
            end
            S_DATA: if (bit_end) begin
                if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = S_PARITY;
                    tx_d    = par_q;
`else
                    state_d = S_STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    bit_d   = bit_q + 3'd1;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_end) begin
                state_d = S_STOP;
                tx_d    = 1'b1;
            end
`endif
            S_STOP: if (bit_end) begin
                if (!fifo_empty) load = 1'b1;
                else             state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // Frame start: divisor is captured here so BAUDDIV writes only affect later frames.
        if (load) begin
            state_d   = S_START;
            shift_d   = fifo_data;
            par_d     = ^fifo_data;
            div_lat_d = baud_q;
            cnt_d     = baud_q;
            tx_d      = 1'b0;
        end
    end

    assign pop = load;

    always_comb begin
        ovf_d = ovf_q;
        if (wr && (off == OFF_STATUS) && bus.wd[ST_OVF]) ovf_d = 1'b0;
        if (push && fifo_full && !pop)                   ovf_d = 1'b1;
        baud_d = baud_q;
        if (wr && (off == OFF_BAUDDIV))
            baud_d = (bus.wd[DIV_W-1:0] == '0) ? DIV_W'(1) : bus.wd[DIV_W-1:0];
        cnt_next = fifo_count + CW'(push_ok) - CW'(pop);
        irq_d    = (state_d == S_IDLE) && (cnt_next == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= DIV_W'(1);
            div_lat_q <= DEFAULT_DIV;
            baud_q    <= DEFAULT_DIV;
            shift_q   <= '0;
            bit_q     <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            irq_q     <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_lat_q <= div_lat_d;
            baud_q    <= baud_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            irq_q     <= irq_d;
            ovf_q     <= ovf_d;
        end
    end

    assign tx          = tx_q;
    assign irq         = irq_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register-map vector table, hand-written frame/overflow/reset
// sequences, and random bursts checked by a frame-level line monitor.
module tb_mmio_uart_tx;
  import uart_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0100;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx, irq;
  uart_state_e dbg_state;
  mmio_uart_tx_if bus ();

  int checks = 0;
  int failures = 0;
  int model_div = 4;
  bit mon_en = 1'b1;
  int mon_busy = 0;
  logic [7:0] exp_q[$];

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .tx(tx), .irq(irq), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h required %08h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.we = 1'b1; bus.a = addr; bus.wd = data;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    if (addr[31:4] == BASE[31:4] && addr[3:2] == 2'd2)
      model_div = (data[15:0] == 16'd0) ? 1 : int'(data[15:0]);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] rdv, output logic hitv);
    @(negedge clk);
    bus.we = 1'b0; bus.a = addr;
    #1;
    rdv = bus.rd; hitv = bus.hit;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] r; logic h;
    bus_read(addr, r, h);
    check(name, r, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_q.push_back(b);
    bus_write(BASE, {24'h0, b});
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && mon_busy == 0 && irq === 1'b1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      failures++;
      $display("FAIL %s_timeout: got pending=%0d irq=%b, required all frames sent", name, exp_q.size(), irq);
    end
  endtask

  // scoreboard: every frame on tx is checked cycle by cycle against the next expected byte
  initial begin : line_monitor
    logic [7:0] exp_b, got;
    logic [FB-1:0] bits;
    int d;
    bit bad;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        mon_busy = 1;
        d = model_div;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL frame_unexpected: got a start bit, required idle line");
          exp_b = 8'h00;
        end else exp_b = exp_q.pop_front();
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = exp_b;
`ifdef UART_TX_PARITY_EN
        bits[9] = ^exp_b;
`endif
        got = 8'h00; bad = 1'b0;
        for (int j = 0; j < FB; j++) begin
          for (int c = 0; c < d; c++) begin
            if (j != 0 || c != 0) @(negedge clk);
            if (tx !== bits[j]) bad = 1'b1;
            if (j >= 1 && j <= 8 && c == 0) got[j-1] = tx;
          end
        end
        checks++;
        if (bad) begin
          failures++;
          $display("FAIL frame: got byte %02h with wrong bit timing/level, required %02h at div %0d", got, exp_b, d);
        end
        mon_busy = 0;
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_hit;
    string       name;
  } vec_t;

  vec_t vecs[20];

  initial begin : stimulus
    logic [31:0] r; logic h;
    int cyc, nb, gap, dv;
    bus.we = 1'b0; bus.a = 32'h0; bus.wd = 32'h0;

    vecs[0]  = '{1'b1, BASE + 32'h8,  32'h0000_0000, 32'h0,          1'b1, "div_w0"};
    vecs[1]  = '{1'b0, BASE + 32'h8,  32'h0,         32'h0000_0001,  1'b1, "div_zero_as_one"};
    vecs[2]  = '{1'b1, BASE + 32'h8,  32'hABCD_0003, 32'h0,          1'b1, "div_w3"};
    vecs[3]  = '{1'b0, BASE + 32'h8,  32'h0,         32'h0000_0003,  1'b1, "div_upper_zero"};
    vecs[4]  = '{1'b1, BASE + 32'h8,  32'h0001_0000, 32'h0,          1'b1, "div_wlow0"};
    vecs[5]  = '{1'b0, BASE + 32'h8,  32'h0,         32'h0000_0001,  1'b1, "div_low0_as_one"};
    vecs[6]  = '{1'b1, BASE + 32'h8,  32'h0000_0004, 32'h0,          1'b1, "div_w4"};
    vecs[7]  = '{1'b0, BASE + 32'h8,  32'h0,         32'h0000_0004,  1'b1, "div_rd4"};
    vecs[8]  = '{1'b0, BASE + 32'h0,  32'h0,         32'h0,          1'b1, "txdata_rd0"};
    vecs[9]  = '{1'b0, BASE + 32'h4,  32'h0,         32'h0000_0004,  1'b1, "status_idle"};
    vecs[10] = '{1'b0, BASE + 32'hC,  32'h0,         32'h0,          1'b1, "rsvd_rd0"};
    vecs[11] = '{1'b1, BASE + 32'hC,  32'hFFFF_FFFF, 32'h0,          1'b1, "rsvd_w"};
    vecs[12] = '{1'b0, BASE + 32'h8,  32'h0,         32'h0000_0004,  1'b1, "div_after_rsvd_w"};
    vecs[13] = '{1'b0, BASE + 32'h10, 32'h0,         32'h0,          1'b0, "outside_hi"};
    vecs[14] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0,          1'b0, "outside_zero"};
    vecs[15] = '{1'b0, BASE + 32'h6,  32'h0,         32'h0000_0004,  1'b1, "status_byteaddr"};
    vecs[16] = '{1'b0, 32'h8000_0104, 32'h0,         32'h0,          1'b0, "outside_top"};
    vecs[17] = '{1'b1, BASE + 32'h10, 32'h0000_0042, 32'h0,          1'b0, "outside_w"};
    vecs[18] = '{1'b0, BASE + 32'h4,  32'h0,         32'h0000_0004,  1'b1, "status_no_push"};
    vecs[19] = '{1'b0, BASE + 32'h8,  32'h0,         32'h0000_0004,  1'b1, "div_final"};

    // reset state (reads are combinational, so they work while reset is held)
    repeat (3) @(negedge clk);
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_irq", {31'h0, irq}, 32'h1);
    read_check("rst_status", BASE + 32'h4, 32'h0000_0004);
    read_check("rst_div", BASE + 32'h8, 32'h0000_0004);
    @(negedge clk) rst = 1'b0;
    model_div = 4;
    repeat (2) @(negedge clk);

    // 0x55 at div 4: fall on the next edge, irq back after a full frame
    send_byte(8'h55);
    check("t1_tx_before_fall", {31'h0, tx}, 32'h1);
    check("t1_irq_low", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    check("t1_tx_fall", {31'h0, tx}, 32'h0);
    cyc = 0;
    @(negedge clk);
    while (cyc < 1000) begin
      @(negedge clk); cyc++;
      if (irq === 1'b1) break;
    end
    check("t1_frame_cycles", cyc, FB * 4);
    wait_done("t1");

    // nine back-to-back writes while idle: first pops, all nine sent
    for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i));
    read_check("t2_status_full", BASE + 32'h4, 32'h0000_0083);
    wait_done("t2a");
    read_check("t2_no_ovf", BASE + 32'h4, 32'h0000_0004);
    // nine more while busy: eight fit, the last is dropped
    send_byte(8'hE0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i));
    bus_write(BASE, 32'h0000_00FF);
    read_check("t2_status_ovf", BASE + 32'h4, 32'h0000_008B);
    bus_write(BASE + 32'h4, 32'h0000_0008);
    read_check("t2_ovf_cleared", BASE + 32'h4, 32'h0000_0083);
    wait_done("t2b");

    // one cycle per bit, then a divisor change mid-frame
    bus_write(BASE + 32'h8, 32'h0);
    read_check("t3_div0_reads1", BASE + 32'h8, 32'h0000_0001);
    send_byte(8'h96);
    wait_done("t3a");
    bus_write(BASE + 32'h8, 32'h4);
    send_byte(8'h3C);
    send_byte(8'hC3);
    repeat (6) @(negedge clk);
    bus_write(BASE + 32'h8, 32'h8);
    read_check("t3_div8", BASE + 32'h8, 32'h0000_0008);
    wait_done("t3b");

    // register-map table
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].a, vecs[i].wd);
      else begin
        bus_read(vecs[i].a, r, h);
        check({vecs[i].name, "_rd"}, r, vecs[i].exp_rd);
        check({vecs[i].name, "_hit"}, {31'h0, h}, {31'h0, vecs[i].exp_hit});
      end
    end

    // parity build sends 11 bit times for 0x07, plain build 10
    send_byte(8'h07);
    @(posedge clk); #1;
    cyc = 0;
    @(negedge clk);
    while (cyc < 1000) begin
      @(negedge clk); cyc++;
      if (irq === 1'b1) break;
    end
    check("t6_frame_cycles", cyc, FB * 4);
    wait_done("t6");

    // random bursts at random divisors
    for (int it = 0; it < 25; it++) begin
      dv = $urandom_range(1, 5);
      bus_write(BASE + 32'h8, 32'(dv));
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        send_byte(8'($urandom_range(0, 255)));
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk);
      end
      wait_done("rand");
    end

    // reset in the middle of data bit 3
    bus_write(BASE + 32'h8, 32'h6);
    mon_en = 1'b0;
    bus_write(BASE, 32'h0000_00A5);
    repeat (27) @(posedge clk);
    #2;
    check("t5_tx_bit3", {31'h0, tx}, 32'h0);
    rst = 1'b1;
    #1;
    check("t5_tx_async", {31'h0, tx}, 32'h1);
    read_check("t5_status", BASE + 32'h4, 32'h0000_0004);
    read_check("t5_div", BASE + 32'h8, 32'h0000_0004);
    check("t5_irq", {31'h0, irq}, 32'h1);
    @(negedge clk) rst = 1'b0;
    model_div = 4;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_idle_after", {31'h0, tx}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
